// File: rtl/max_search_pkg.sv
// Shared types and default widths for the max_search_ctrl frame-maximum controller.
package max_search_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_IDX_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] max;
        logic [DEF_IDX_W-1:0]  idx;
        logic [DEF_IDX_W:0]    count;
        logic                  trunc;
    } result_t;

endpackage

// File: rtl/signed_max_cmp.sv
// Combinational signed two's-complement compare: gt = (a > b), max = larger operand.
module signed_max_cmp
    import max_search_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic [DATA_W-1:0] max
);

    always_comb begin
        // Differing signs: the non-negative operand wins; otherwise magnitudes order directly.
        if (a[DATA_W-1] != b[DATA_W-1]) begin
            gt = ~a[DATA_W-1];
        end else begin
            gt = a[DATA_W-2:0] > b[DATA_W-2:0];
        end
        max = gt ? a : b;
    end

endmodule

// File: rtl/max_search_ctrl.sv
// Streams signed samples through a shared compare stage and reports frame max/index/count.
// Optional minimum tracking (out_min, out_min_idx) is built when MAX_SEARCH_MIN_TRACK_EN is defined.
module max_search_ctrl
    import max_search_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_count,
    output logic              out_trunc,
`ifdef MAX_SEARCH_MIN_TRACK_EN
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_min_idx,
`endif
    output logic              busy
);

    localparam logic [IDX_W:0] CNT_ONE   = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W:0] CNT_LIMIT = {1'b1, {IDX_W{1'b0}}};

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  max_q, max_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               trunc_q, trunc_d;
    logic [IDX_W:0]     cnt_inc;
    logic               new_max;
    logic [DATA_W-1:0]  cmp_max;

    assign cnt_inc = cnt_q + CNT_ONE;

    signed_max_cmp #(.DATA_W(DATA_W)) u_max_cmp (
        .a   (in_data),
        .b   (max_q),
        .gt  (new_max),
        .max (cmp_max)
    );

`ifdef MAX_SEARCH_MIN_TRACK_EN
    logic [DATA_W-1:0]  min_q, min_d;
    logic [IDX_W-1:0]   min_idx_q, min_idx_d;
    logic               new_min;
    logic [DATA_W-1:0]  min_cmp_max;
    logic [DATA_W-1:0]  min_sel;

    // Swapped operands: gt means the stored minimum exceeds the sample.
    signed_max_cmp #(.DATA_W(DATA_W)) u_min_cmp (
        .a   (min_q),
        .b   (in_data),
        .gt  (new_min),
        .max (min_cmp_max)
    );

    // XOR of both operands with the larger one leaves the smaller one.
    assign min_sel     = min_q ^ in_data ^ min_cmp_max;
    assign out_min     = min_q;
    assign out_min_idx = min_idx_q;
`endif

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        trunc_d   = trunc_q;
`ifdef MAX_SEARCH_MIN_TRACK_EN
        min_d     = min_q;
        min_idx_d = min_idx_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    max_d     = in_data;
                    idx_d     = '0;
                    cnt_d     = CNT_ONE;
                    trunc_d   = 1'b0;
`ifdef MAX_SEARCH_MIN_TRACK_EN
                    min_d     = in_data;
                    min_idx_d = '0;
`endif
                    state_d   = in_last ? DONE : SCAN;
                end
            end
            SCAN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_inc;
                    if (new_max) begin
                        max_d = cmp_max;
                        idx_d = cnt_q[IDX_W-1:0];
                    end
`ifdef MAX_SEARCH_MIN_TRACK_EN
                    if (new_min) begin
                        min_d     = min_sel;
                        min_idx_d = cnt_q[IDX_W-1:0];
                    end
`endif
                    if (in_last) begin
                        state_d = DONE;
                    end else if (cnt_inc == CNT_LIMIT) begin
                        state_d = DONE;
                        trunc_d = 1'b1;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            max_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            trunc_q   <= 1'b0;
`ifdef MAX_SEARCH_MIN_TRACK_EN
            min_q     <= '0;
            min_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            trunc_q   <= trunc_d;
`ifdef MAX_SEARCH_MIN_TRACK_EN
            min_q     <= min_d;
            min_idx_q <= min_idx_d;
`endif
        end
    end

    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_count = cnt_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_max_search_ctrl.sv
// Self-checking bench for max_search_ctrl: directed frames plus randomized scoreboard traffic.
module tb_max_search_ctrl;
    import max_search_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_trunc, busy;
    logic [7:0] out_max, out_idx;
    logic [8:0] out_count;
`ifdef MAX_SEARCH_MIN_TRACK_EN
    logic [7:0] out_min, out_min_idx;
`endif

    max_search_ctrl #(.DATA_W(8), .IDX_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_idx     (out_idx),
        .out_count   (out_count),
        .out_trunc   (out_trunc),
`ifdef MAX_SEARCH_MIN_TRACK_EN
        .out_min     (out_min),
        .out_min_idx (out_min_idx),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        result_t    r;
        logic [7:0] min;
        logic [7:0] min_idx;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    logic signed [7:0] m_max, m_min;
    int                m_idx, m_min_idx, m_cnt;
    bit                m_open  = 1'b0;
    bit                rand_bp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic l);
        exp_t e;
        if (!m_open) begin
            m_max = d; m_min = d; m_idx = 0; m_min_idx = 0; m_cnt = 1; m_open = 1'b1;
        end else begin
            if ($signed(d) > m_max) begin m_max = d; m_idx = m_cnt; end
            if ($signed(d) < m_min) begin m_min = d; m_min_idx = m_cnt; end
            m_cnt++;
        end
        if (l || m_cnt == 256) begin
            e.r.max   = m_max;
            e.r.idx   = m_idx[7:0];
            e.r.count = m_cnt[8:0];
            e.r.trunc = !l;
            e.min     = m_min;
            e.min_idx = m_min_idx[7:0];
            sb.push_back(e);
            m_open = 1'b0;
        end
    endtask

    // Holds the beat until accepted; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!acc && n < 2000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
        check("beat_accepted", {31'd0, acc}, 32'd1);
        if (acc) model_accept(d, l);
    endtask

    always @(negedge clk) begin : mon_blk
        exp_t e;
        if (rst_n && out_valid) begin
            check("no_accept_in_done", {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow observed=result expected=none");
                end else begin
                    e = sb.pop_front();
                    check("sb_max",   {24'd0, out_max},   {24'd0, e.r.max});
                    check("sb_idx",   {24'd0, out_idx},   {24'd0, e.r.idx});
                    check("sb_count", {23'd0, out_count}, {23'd0, e.r.count});
                    check("sb_trunc", {31'd0, out_trunc}, {31'd0, e.r.trunc});
`ifdef MAX_SEARCH_MIN_TRACK_EN
                    check("sb_min",     {24'd0, out_min},     {24'd0, e.min});
                    check("sb_min_idx", {24'd0, out_min_idx}, {24'd0, e.min_idx});
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_bp) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         len;
        int         n;
        logic [7:0] v;
        logic [7:0] corner[4];
        corner[0] = 8'h80; corner[1] = 8'h7F; corner[2] = 8'h00; corner[3] = 8'hFF;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_max",       {24'd0, out_max},   32'd0);
        check("rst_idx",       {24'd0, out_idx},   32'd0);
        check("rst_count",     {23'd0, out_count}, 32'd0);
        check("rst_trunc",     {31'd0, out_trunc}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mixed-sign frame; result must appear the cycle after the last beat.
        out_ready = 1'b1;
        send_beat(8'h05, 1'b0);
        check("scan_busy", {31'd0, busy}, 32'd1);
        send_beat(8'h80, 1'b0);
        send_beat(8'h7F, 1'b0);
        send_beat(8'h10, 1'b1);
        check("f1_latency", {31'd0, out_valid}, 32'd1);
        check("f1_max",     {24'd0, out_max},   32'h7F);
        check("f1_idx",     {24'd0, out_idx},   32'd2);
        check("f1_count",   {23'd0, out_count}, 32'd4);
        check("f1_trunc",   {31'd0, out_trunc}, 32'd0);
        @(posedge clk); #1;
        check("f1_handoff", {31'd0, out_valid}, 32'd0);

        // All-negative frame with a tie on the maximum.
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFE, 1'b0);
        send_beat(8'hFF, 1'b1);
        check("f2_max", {24'd0, out_max}, 32'hFF);
        check("f2_idx", {24'd0, out_idx}, 32'd0);
`ifdef MAX_SEARCH_MIN_TRACK_EN
        check("f2_min",     {24'd0, out_min},     32'hFE);
        check("f2_min_idx", {24'd0, out_min_idx}, 32'd1);
`endif
        @(posedge clk); #1;

        // Single-beat frame stalled by the consumer; ignored input traffic during the stall.
        out_ready = 1'b0;
        send_beat(8'h80, 1'b1);
        check("f3_valid", {31'd0, out_valid}, 32'd1);
        check("f3_busy",  {31'd0, busy},      32'd0);
        in_valid = 1'b1; in_data = 8'h7F; in_last = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("f3_stall_valid", {31'd0, out_valid}, 32'd1);
            check("f3_stall_ready", {31'd0, in_ready},  32'd0);
            check("f3_stall_max",   {24'd0, out_max},   32'h80);
            check("f3_stall_count", {23'd0, out_count}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("f3_handoff", {31'd0, out_valid}, 32'd0);

        // Length limit without in_last forces truncation.
        for (int i = 0; i < 256; i++) send_beat(8'h01, 1'b0);
        check("f4_valid", {31'd0, out_valid}, 32'd1);
        check("f4_count", {23'd0, out_count}, 32'd256);
        check("f4_trunc", {31'd0, out_trunc}, 32'd1);
        check("f4_idx",   {24'd0, out_idx},   32'd0);
        @(posedge clk); #1;

        // Length limit coinciding with in_last closes legitimately.
        for (int i = 0; i < 256; i++) send_beat(8'h01, i == 255);
        check("f5_count", {23'd0, out_count}, 32'd256);
        check("f5_trunc", {31'd0, out_trunc}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-frame discards the partial frame.
        send_beat(8'h11, 1'b0);
        send_beat(8'h7E, 1'b0);
        send_beat(8'h33, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",     {31'd0, busy},      32'd0);
        check("arst_in_ready", {31'd0, in_ready},  32'd1);
        check("arst_max",      {24'd0, out_max},   32'd0);
        check("arst_idx",      {24'd0, out_idx},   32'd0);
        check("arst_count",    {23'd0, out_count}, 32'd0);
        m_open = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b1);
        check("f6_max",   {24'd0, out_max},   32'h33);
        check("f6_idx",   {24'd0, out_idx},   32'd1);
        check("f6_count", {23'd0, out_count}, 32'd2);
        @(posedge clk); #1;

        // Random gaps and backpressure, checked through the scoreboard.
        rand_bp = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 1) == 1) v = 8'($urandom);
                else v = corner[$urandom_range(0, 3)];
                send_beat(v, b == len - 1);
            end
        end
        rand_bp = 1'b0;
        @(posedge clk); #3;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_search_ctrl.md
Name: max_search_ctrl

Overview:
- Sequential controller that streams signed two's-complement samples through one shared signed-max compare stage.
- Reports the frame maximum, its index, and the beat count.
- Sits between a sample source (valid/ready/last stream) and a result consumer (valid/ready).
- One frame is in flight at a time; no result buffering beyond a single holding register.

Parameters:
- DATA_W, 8, sample width, signed two's complement.
- IDX_W, 8, index width; max frame length is 2**IDX_W beats.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source beat valid.
- in_ready  out  1  controller accepts a beat.
- in_data  in  DATA_W  signed sample.
- in_last  in  1  final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_max  out  DATA_W  frame maximum, signed.
- out_idx  out  IDX_W  index of the first occurrence of the maximum.
- out_count  out  IDX_W+1  beats in the frame, 1..2**IDX_W.
- out_trunc  out  1  frame force-closed at the length limit.
- busy  out  1  frame in progress (state SCAN).

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_max, out_idx, out_count and out_trunc all 0.
  - Reset mid-frame or mid-result discards everything; the next beat after release starts a new frame.
- Accept = in_valid & in_ready. Result handoff = out_valid & out_ready.
- States:
  - IDLE: in_ready=1. On accept: max_r=in_data, idx_r=0, cnt_r=1, trunc_r=0. If in_last, go to DONE; else go to SCAN.
  - SCAN: in_ready=1, busy=1. On accept: cnt_r+1. If in_data > max_r (signed, strict), then max_r=in_data and idx_r=cnt_r (the index before increment).
    - Ties keep the earlier index.
    - If in_last, go to DONE.
    - If in_last=0 and the new count equals 2**IDX_W: go to DONE with trunc_r=1.
  - DONE: in_ready=0, out_valid=1. Outputs are driven from the registers and held stable while out_valid & !out_ready. On handoff, go to IDLE.
- Latency: out_valid asserts the cycle after the accepting edge of the last beat.
- Back-to-back frames: the earliest next-frame accept is the cycle after handoff. in_ready is combinational from state only, never from out_ready.
- Signed compare rules:
  - If the sign bits differ, the operand with sign=0 is larger.
  - If the sign bits match, compare the lower DATA_W-1 bits unsigned.
  - Examples: 0x7F > 0x00 > 0xFF > 0x80.
- in_valid with no accept: no state change. in_data and in_last are ignored while in_ready=0.
- in_last on a beat that also hits the length limit: trunc_r=0, because the frame ended legitimately.
- out_count never wraps; it is IDX_W+1 bits so 2**IDX_W is representable.

Optional Feature:
- Macro MAX_SEARCH_MIN_TRACK_EN.
- Defined:
  - Adds ports out_min (DATA_W) and out_min_idx (IDX_W).
  - These track the signed minimum with strict less-than, so ties keep the earlier index.
  - Same load/reset/hold rules as out_max/out_idx.
  - Uses a second compare instance.
- Undefined: ports are absent, no min logic is built, and behaviour is otherwise identical.

Decomposition:
- Package max_search_pkg holds:
  - state enum {IDLE, SCAN, DONE}, 2 bits;
  - default DATA_W and IDX_W constants;
  - a result struct {max, idx, count, trunc}.
- Sub-module signed_max_cmp:
  - purely combinational;
  - inputs a and b (DATA_W);
  - outputs gt (a > b, signed) and the max value.
  - Instantiated once, twice with MAX_SEARCH_MIN_TRACK_EN (operands swapped to obtain less-than).

Test Plan:
- Frame 0x05,0x80,0x7F,0x10 (last on 4th), out_ready=1 -> out_valid the cycle after beat 4; out_max=0x7F, out_idx=2, out_count=4, out_trunc=0.
- Frame 0xFF,0xFE,0xFF (all negative) -> out_max=0xFF, out_idx=0 (tie keeps first); with MIN_TRACK: out_min=0xFE, out_min_idx=1.
- Single-beat frame 0x80 with in_last, then out_ready held 0 for 5 cycles -> IDLE to DONE directly; out_max=0x80, out_count=1; outputs stable and in_ready=0 throughout the stall.
- 256 beats of 0x01 with in_last never asserted (IDX_W=8) -> DONE after beat 256; out_count=256, out_trunc=1, out_idx=0. Repeat with in_last on beat 256 -> out_trunc=0.
- rst_n pulsed low mid-SCAN after 3 beats -> all outputs 0 asynchronously; next frame 0x22,0x33(last) -> out_max=0x33, out_idx=1, out_count=2.
- Random in_valid gaps and out_ready backpressure over 1000 frames -> scoreboard max, idx and count against a model; no beat accepted while out_valid=1.
